// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the uart_xcvr transceiver.
//   parity_e   : line parity mode (none / odd / even)
//   tx_state_t : transmitter FSM states
//   rx_state_t : receiver FSM states
//   calcDiv    : clocks per oversample tick, never below 1
//   calcParity : parity bit over the low dataBits bits of a padded word
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_t;

  // Widest payload supported; narrower words are zero-padded up to this.
  localparam int MAX_DATA_BITS = 9;

  // Integer division, clamped so that very fast baud rates still tick.
  function automatic int calcDiv(input int clkFreq, input int baudRate,
                                 input int overSample);
    int div;
    div = clkFreq / (baudRate * overSample);
    if (div < 1) div = 1;
    return div;
  endfunction

  // Even parity is the plain XOR of the payload; odd parity inverts it.
  // Bits at or above dataBits are ignored.
  function automatic logic calcParity(input logic [MAX_DATA_BITS-1:0] data,
                                      input int dataBits, input parity_e mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < dataBits) p = p ^ data[i];
    end
    if (mode == PAR_ODD) p = ~p;
    else if (mode == PAR_NONE) p = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through FIFO holding received words plus their error flags.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointers only)
//   push_i      : write pushData_i (accepted when not full, or when a pop
//                 frees a slot in the same cycle)
//   pushData_i  : entry to store
//   pop_i       : drop the head entry (ignored when empty)
//   popData_o   : head entry, forced to zero when empty
//   full_o      : no free slot
//   empty_o     : no stored entry
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popData_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match. A push into a full FIFO is still taken when
  // the head is popped in the same cycle: it lands in the slot being freed.
  // The head is zeroed while empty so stale storage never shows on the port.
  always_comb begin
    empty_o   = (wrPtr_q == rdPtr_q);
    full_o    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    doPop     = pop_i && !empty_o;
    doPush    = push_i && (!full_o || doPop);
    wrPtr_d   = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d   = doPop ? rdPtr_q + 1'b1 : rdPtr_q;
    popData_o = empty_o ? '0 : mem[rdPtr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage is not reset; the empty gating above hides its contents.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q[AW-1:0]] <= pushData_i;
  end

endmodule

// File: rtl/uart_xcvr.sv
// ---------------------------------------------------------------------------
// uart_xcvr
// Parametrised full-duplex UART: oversample tick generator, transmitter with
// valid/ready input, receiver with false-start rejection and parity/framing
// checks, and an FWFT receive FIFO.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   tx_data/tx_valid      : word to send and its request
//   tx_ready              : transmitter idle, accepts a word this cycle
//   txd                   : serial output, idles high
//   rxd                   : serial input, asynchronous to clk
//   rx_data/perr/ferr     : FIFO head word and its error flags
//   rx_valid/rx_ready     : FIFO not empty / pop request
//   rx_overrun, ovr_clr   : sticky dropped-word flag and its clear
//   loopback              : route txd into the receiver
// Build option: define UART_XCVR_LOOPBACK_EN to build the loopback mux;
// otherwise loopback is ignored.
// ---------------------------------------------------------------------------
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic                 ovr_clr,
  input  logic                 loopback
);

  localparam int      DIV      = calcDiv(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int      BIT_T    = DIV * OVERSAMPLE;
  localparam int      STOP_T   = STOP_BITS * BIT_T;
  localparam int      TT_W     = $clog2(STOP_T + 1);
  localparam int      OS_W     = $clog2(OVERSAMPLE);
  localparam int      BC_W     = 4;
  localparam int      FIFO_W   = DATA_BITS + 2;
  localparam parity_e PAR_MODE = parity_e'(PARITY);
  localparam bit      PAR_EN   = (PARITY != 0);

  // -------------------------------------------------------------------------
  // Oversample tick generator
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic             tick;

  // Fires once every DIV clocks; with DIV == 1 it is permanently high.
  always_comb begin
    tick     = (divCnt_q == DIV_W'(DIV - 1));
    divCnt_d = tick ? '0 : divCnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) divCnt_q <= '0;
    else        divCnt_q <= divCnt_d;
  end

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  tx_state_t                txState_q, txState_d;
  logic [TT_W-1:0]          txTimer_q, txTimer_d;
  logic [BC_W-1:0]          txBitCnt_q, txBitCnt_d;
  logic [DATA_BITS-1:0]     txShift_q, txShift_d;
  logic                     txPar_q, txPar_d;
  logic                     txd_q, txd_d;
  logic [MAX_DATA_BITS-1:0] txPadded;

  always_comb begin
    txPadded = '0;
    txPadded[DATA_BITS-1:0] = tx_data;
  end

  // txd is registered and updated on the same edge as the state, so each
  // level appears on the pin exactly when its state is entered. The bit
  // timer counts raw clocks, independent of the shared tick, and restarts on
  // every accept so frames are not aligned to the tick phase.
  always_comb begin
    txState_d  = txState_q;
    txTimer_d  = txTimer_q;
    txBitCnt_d = txBitCnt_q;
    txShift_d  = txShift_q;
    txPar_d    = txPar_q;
    txd_d      = txd_q;
    case (txState_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (tx_valid) begin
          txShift_d = tx_data;
          txPar_d   = calcParity(txPadded, DATA_BITS, PAR_MODE);
          txTimer_d = '0;
          txState_d = TX_START;
          txd_d     = 1'b0;
        end
      end
      TX_START: begin
        if (txTimer_q == TT_W'(BIT_T - 1)) begin
          txTimer_d  = '0;
          txBitCnt_d = '0;
          txState_d  = TX_DATA;
          txd_d      = txShift_q[0];
        end else begin
          txTimer_d = txTimer_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (txTimer_q == TT_W'(BIT_T - 1)) begin
          txTimer_d = '0;
          if (txBitCnt_q == BC_W'(DATA_BITS - 1)) begin
            if (PAR_EN) begin
              txState_d = TX_PAR;
              txd_d     = txPar_q;
            end else begin
              txState_d = TX_STOP;
              txd_d     = 1'b1;
            end
          end else begin
            txBitCnt_d = txBitCnt_q + 1'b1;
            txShift_d  = {1'b0, txShift_q[DATA_BITS-1:1]};
            txd_d      = txShift_q[1];
          end
        end else begin
          txTimer_d = txTimer_q + 1'b1;
        end
      end
      TX_PAR: begin
        if (txTimer_q == TT_W'(BIT_T - 1)) begin
          txTimer_d = '0;
          txState_d = TX_STOP;
          txd_d     = 1'b1;
        end else begin
          txTimer_d = txTimer_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (txTimer_q == TT_W'(STOP_T - 1)) begin
          txTimer_d = '0;
          txState_d = TX_IDLE;
          txd_d     = 1'b1;
        end else begin
          txTimer_d = txTimer_q + 1'b1;
        end
      end
      default: begin
        txState_d = TX_IDLE;
        txd_d     = 1'b1;
      end
    endcase
  end

  // Transmitter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState_q  <= TX_IDLE;
      txTimer_q  <= '0;
      txBitCnt_q <= '0;
      txShift_q  <= '0;
      txPar_q    <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      txState_q  <= txState_d;
      txTimer_q  <= txTimer_d;
      txBitCnt_q <= txBitCnt_d;
      txShift_q  <= txShift_d;
      txPar_q    <= txPar_d;
      txd_q      <= txd_d;
    end
  end

  assign tx_ready = (txState_q == TX_IDLE);
  assign txd      = txd_q;

  // -------------------------------------------------------------------------
  // Receiver input stage
  // -------------------------------------------------------------------------
  logic rxIn;

`ifdef UART_XCVR_LOOPBACK_EN
  assign rxIn = loopback ? txd_q : rxd;
`else
  logic unusedLoopback;
  assign unusedLoopback = loopback;
  assign rxIn = rxd;
`endif

  logic rxSync1_q, rxSync2_q, rxPrev_q;
  logic rxFall;

  // Two-flop synchroniser plus one history flop for edge detection. All
  // reset high so the idle line does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
      rxPrev_q  <= 1'b1;
    end else begin
      rxSync1_q <= rxIn;
      rxSync2_q <= rxSync1_q;
      rxPrev_q  <= rxSync2_q;
    end
  end

  assign rxFall = rxPrev_q & ~rxSync2_q;

  // -------------------------------------------------------------------------
  // Receiver FSM
  // -------------------------------------------------------------------------
  rx_state_t                rxState_q, rxState_d;
  logic [OS_W-1:0]          rxTickCnt_q, rxTickCnt_d;
  logic [BC_W-1:0]          rxBitCnt_q, rxBitCnt_d;
  logic [DATA_BITS-1:0]     rxShift_q, rxShift_d;
  logic                     rxParBit_q, rxParBit_d;
  logic [MAX_DATA_BITS-1:0] rxPadded;
  logic                     rxPerr;
  logic                     fifoPush;
  logic [FIFO_W-1:0]        fifoPushData;

  always_comb begin
    rxPadded = '0;
    rxPadded[DATA_BITS-1:0] = rxShift_q;
    rxPerr = PAR_EN && (rxParBit_q != calcParity(rxPadded, DATA_BITS, PAR_MODE));
  end

  // The start bit is re-checked half a bit after the edge; from there every
  // sample lands one full bit later, i.e. mid-bit. Only the first stop bit is
  // sampled; a low there is a framing error, and since the FSM only leaves
  // IDLE on a falling edge, a line stuck low cannot retrigger a frame.
  always_comb begin
    rxState_d    = rxState_q;
    rxTickCnt_d  = rxTickCnt_q;
    rxBitCnt_d   = rxBitCnt_q;
    rxShift_d    = rxShift_q;
    rxParBit_d   = rxParBit_q;
    fifoPush     = 1'b0;
    fifoPushData = '0;
    case (rxState_q)
      RX_IDLE: begin
        if (rxFall) begin
          rxTickCnt_d = '0;
          rxState_d   = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rxTickCnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
            rxTickCnt_d = '0;
            rxBitCnt_d  = '0;
            rxState_d   = rxSync2_q ? RX_IDLE : RX_DATA;
          end else begin
            rxTickCnt_d = rxTickCnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rxTickCnt_q == OS_W'(OVERSAMPLE - 1)) begin
            rxTickCnt_d = '0;
            rxShift_d   = {rxSync2_q, rxShift_q[DATA_BITS-1:1]};
            if (rxBitCnt_q == BC_W'(DATA_BITS - 1)) begin
              rxState_d = PAR_EN ? RX_PAR : RX_STOP;
            end else begin
              rxBitCnt_d = rxBitCnt_q + 1'b1;
            end
          end else begin
            rxTickCnt_d = rxTickCnt_q + 1'b1;
          end
        end
      end
      RX_PAR: begin
        if (tick) begin
          if (rxTickCnt_q == OS_W'(OVERSAMPLE - 1)) begin
            rxTickCnt_d = '0;
            rxParBit_d  = rxSync2_q;
            rxState_d   = RX_STOP;
          end else begin
            rxTickCnt_d = rxTickCnt_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rxTickCnt_q == OS_W'(OVERSAMPLE - 1)) begin
            rxTickCnt_d  = '0;
            fifoPush     = 1'b1;
            fifoPushData = {rxShift_q, rxPerr, ~rxSync2_q};
            rxState_d    = RX_IDLE;
          end else begin
            rxTickCnt_d = rxTickCnt_q + 1'b1;
          end
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxState_q   <= RX_IDLE;
      rxTickCnt_q <= '0;
      rxBitCnt_q  <= '0;
      rxShift_q   <= '0;
      rxParBit_q  <= 1'b0;
    end else begin
      rxState_q   <= rxState_d;
      rxTickCnt_q <= rxTickCnt_d;
      rxBitCnt_q  <= rxBitCnt_d;
      rxShift_q   <= rxShift_d;
      rxParBit_q  <= rxParBit_d;
    end
  end

  // -------------------------------------------------------------------------
  // Receive FIFO and overrun flag
  // -------------------------------------------------------------------------
  logic [FIFO_W-1:0] fifoHead;
  logic              fifoFull, fifoEmpty, fifoPop;
  logic              overrunEvent;
  logic              rxOverrun_q;

  uart_rx_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifoPush),
    .pushData_i (fifoPushData),
    .pop_i      (fifoPop),
    .popData_o  (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  assign rx_valid     = ~fifoEmpty;
  assign fifoPop      = rx_valid && rx_ready;
  assign overrunEvent = fifoPush && fifoFull && !fifoPop;
  assign rx_data      = fifoHead[FIFO_W-1:2];
  assign rx_perr      = fifoHead[1];
  assign rx_ferr      = fifoHead[0];

  // Sticky drop flag; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rxOverrun_q <= 1'b0;
    else if (overrunEvent) rxOverrun_q <= 1'b1;
    else if (ovr_clr)      rxOverrun_q <= 1'b0;
  end

  assign rx_overrun = rxOverrun_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// ---------------------------------------------------------------------------
// tb_uart_xcvr
// Directed bench for uart_xcvr at 16 MHz / 1 Mbaud / x16 (DIV=1, T=16).
// Three instances cover the formats needed:
//   uA : 8N1, FIFO depth 2 (TX frame, framing error, overrun, reset)
//   uB : 8E1, rxd tied to its own txd (loopback)
//   uC : 8O1 (parity error)
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_xcvr;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [7:0] aTxData, aRxData;
  logic aTxValid, aTxReady, aTxd, aRxd, aRxPerr, aRxFerr, aRxValid;
  logic aRxReady, aRxOverrun, aOvrClr;

  logic [7:0] bTxData, bRxData;
  logic bTxValid, bTxReady, bTxd, bRxPerr, bRxFerr, bRxValid;
  logic bRxReady, bRxOverrun;

  logic [7:0] cTxData, cRxData;
  logic cTxValid, cTxReady, cTxd, cRxd, cRxPerr, cRxFerr, cRxValid;
  logic cRxReady, cRxOverrun;

  uart_xcvr #(
    .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(2)
  ) uA (
    .clk(clk), .rst_n(rst_n), .tx_data(aTxData), .tx_valid(aTxValid),
    .tx_ready(aTxReady), .txd(aTxd), .rxd(aRxd), .rx_data(aRxData),
    .rx_perr(aRxPerr), .rx_ferr(aRxFerr), .rx_valid(aRxValid),
    .rx_ready(aRxReady), .rx_overrun(aRxOverrun), .ovr_clr(aOvrClr),
    .loopback(1'b0)
  );

  // The line-level loop makes this instance self-receive in either build.
  uart_xcvr #(
    .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)
  ) uB (
    .clk(clk), .rst_n(rst_n), .tx_data(bTxData), .tx_valid(bTxValid),
    .tx_ready(bTxReady), .txd(bTxd), .rxd(bTxd), .rx_data(bRxData),
    .rx_perr(bRxPerr), .rx_ferr(bRxFerr), .rx_valid(bRxValid),
    .rx_ready(bRxReady), .rx_overrun(bRxOverrun), .ovr_clr(1'b0),
    .loopback(1'b1)
  );

  uart_xcvr #(
    .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)
  ) uC (
    .clk(clk), .rst_n(rst_n), .tx_data(cTxData), .tx_valid(cTxValid),
    .tx_ready(cTxReady), .txd(cTxd), .rxd(cRxd), .rx_data(cRxData),
    .rx_perr(cRxPerr), .rx_ferr(cRxFerr), .rx_valid(cRxValid),
    .rx_ready(cRxReady), .rx_overrun(cRxOverrun), .ovr_clr(1'b0),
    .loopback(1'b0)
  );

  // Drives a frame onto aRxd (target 0) or cRxd (target 1), LSB first, each
  // bit held T clocks, then returns the line to idle.
  task automatic driveFrame(input int target, input logic [15:0] bits,
                            input int nBits);
    for (int i = 0; i < nBits; i++) begin
      if (target == 0) aRxd = bits[i];
      else             cRxd = bits[i];
      repeat (T) @(negedge clk);
    end
    aRxd = 1'b1;
    cRxd = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    aTxData = '0; aTxValid = 0; aRxd = 1; aRxReady = 0; aOvrClr = 0;
    bTxData = '0; bTxValid = 0; bRxReady = 0;
    cTxData = '0; cTxValid = 0; cRxd = 1; cRxReady = 0;
    repeat (3) @(negedge clk);
    checks++; if (aTxd !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd: got %b want 1", aTxd); end
    checks++; if (aTxReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_ready: got %b want 1", aTxReady); end
    checks++; if (aRxValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b want 0", aRxValid); end
    checks++; if (aRxData !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %h want 00", aRxData); end
    checks++; if ({aRxPerr, aRxFerr} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rx_flags: got %b want 00", {aRxPerr, aRxFerr}); end
    checks++; if ({aRxOverrun, bRxOverrun, cRxOverrun} !== 3'b000) begin errors++; $display("[TB] FAIL reset_overrun: got %b want 000", {aRxOverrun, bRxOverrun, cRxOverrun}); end
    checks++; if ({bTxd, bTxReady, cTxd, cTxReady} !== 4'b1111) begin errors++; $display("[TB] FAIL reset_other_tx: got %b want 1111", {bTxd, bTxReady, cTxd, cTxReady}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // 0xA5 LSB first with start and stop: 0,1,0,1,0,0,1,0,1,1 (index = bit).
  task automatic test_tx_frame();
    logic [9:0] pat;
    pat = 10'b1101001010;
    aTxData = 8'hA5; aTxValid = 1'b1;
    @(negedge clk);
    aTxValid = 1'b0;
    checks++; if (aTxReady !== 1'b0) begin errors++; $display("[TB] FAIL tx_ready_drop: got %b want 0", aTxReady); end
    checks++; if (aTxd !== 1'b0) begin errors++; $display("[TB] FAIL tx_start_low: got %b want 0", aTxd); end
    for (int n = 1; n <= 10 * T; n++) begin
      @(negedge clk);
      if (n % T == T / 2) begin
        checks++;
        if (aTxd !== pat[n / T]) begin errors++; $display("[TB] FAIL tx_bit%0d: got %b want %b", n / T, aTxd, pat[n / T]); end
      end
      if (n == 10 * T - 1) begin
        checks++; if (aTxReady !== 1'b0) begin errors++; $display("[TB] FAIL tx_ready_early: got %b want 0 at 159", aTxReady); end
      end
      if (n == 10 * T) begin
        checks++; if (aTxReady !== 1'b1) begin errors++; $display("[TB] FAIL tx_ready_rise: got %b want 1 at 160", aTxReady); end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  // 0x3C has four ones, so even parity is 0 and the round trip is clean.
  task automatic test_loopback();
    bTxData = 8'h3C; bTxValid = 1'b1;
    @(negedge clk);
    bTxValid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 10 * T) begin
        checks++; if (bRxValid !== 1'b0) begin errors++; $display("[TB] FAIL lb_valid_early: got %b want 0", bRxValid); end
      end
    end
    checks++; if (bRxValid !== 1'b1) begin errors++; $display("[TB] FAIL lb_valid: got %b want 1", bRxValid); end
    checks++; if (bRxData !== 8'h3C) begin errors++; $display("[TB] FAIL lb_data: got %h want 3c", bRxData); end
    checks++; if ({bRxPerr, bRxFerr} !== 2'b00) begin errors++; $display("[TB] FAIL lb_flags: got %b want 00", {bRxPerr, bRxFerr}); end
    bRxReady = 1'b1;
    @(negedge clk);
    bRxReady = 1'b0;
    checks++; if (bRxValid !== 1'b0) begin errors++; $display("[TB] FAIL lb_pop: got %b want 0", bRxValid); end
  endtask

  // Odd parity: 0x01 needs parity 0, so sending 1 is an error; 0x03 needs 1.
  task automatic test_parity_error();
    driveFrame(1, 16'h0602, 11);
    checks++; if (cRxValid !== 1'b1) begin errors++; $display("[TB] FAIL perr_valid: got %b want 1", cRxValid); end
    checks++; if (cRxData !== 8'h01) begin errors++; $display("[TB] FAIL perr_data: got %h want 01", cRxData); end
    checks++; if ({cRxPerr, cRxFerr} !== 2'b10) begin errors++; $display("[TB] FAIL perr_flags: got %b want 10", {cRxPerr, cRxFerr}); end
    cRxReady = 1'b1;
    @(negedge clk);
    cRxReady = 1'b0;
    checks++; if (cRxValid !== 1'b0) begin errors++; $display("[TB] FAIL perr_pop: got %b want 0", cRxValid); end
    driveFrame(1, 16'h0606, 11);
    checks++; if (cRxData !== 8'h03) begin errors++; $display("[TB] FAIL podd_data: got %h want 03", cRxData); end
    checks++; if ({cRxValid, cRxPerr, cRxFerr} !== 3'b100) begin errors++; $display("[TB] FAIL podd_flags: got %b want 100", {cRxValid, cRxPerr, cRxFerr}); end
    cRxReady = 1'b1;
    @(negedge clk);
    cRxReady = 1'b0;
  endtask

  // 0x55 with a low stop bit, then a 4-clock glitch, then a clean 0x5A.
  task automatic test_framing();
    driveFrame(0, 16'h00AA, 10);
    checks++; if (aRxValid !== 1'b1) begin errors++; $display("[TB] FAIL ferr_valid: got %b want 1", aRxValid); end
    checks++; if (aRxData !== 8'h55) begin errors++; $display("[TB] FAIL ferr_data: got %h want 55", aRxData); end
    checks++; if ({aRxPerr, aRxFerr} !== 2'b01) begin errors++; $display("[TB] FAIL ferr_flags: got %b want 01", {aRxPerr, aRxFerr}); end
    aRxReady = 1'b1;
    @(negedge clk);
    aRxReady = 1'b0;
    checks++; if (aRxValid !== 1'b0) begin errors++; $display("[TB] FAIL ferr_pop: got %b want 0", aRxValid); end
    aRxd = 1'b0;
    repeat (4) @(negedge clk);
    aRxd = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (aRxValid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_push: got %b want 0", aRxValid); end
    driveFrame(0, 16'h02B4, 10);
    checks++; if (aRxData !== 8'h5A) begin errors++; $display("[TB] FAIL recover_data: got %h want 5a", aRxData); end
    checks++; if ({aRxValid, aRxPerr, aRxFerr} !== 3'b100) begin errors++; $display("[TB] FAIL recover_flags: got %b want 100", {aRxValid, aRxPerr, aRxFerr}); end
    aRxReady = 1'b1;
    @(negedge clk);
    aRxReady = 1'b0;
  endtask

  // Depth-2 FIFO receives 0x11, 0x22, 0x33 with no pops; 0x33 is dropped.
  task automatic test_overrun();
    driveFrame(0, 16'h0222, 10);
    driveFrame(0, 16'h0244, 10);
    checks++; if (aRxOverrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_two_words: got %b want 0", aRxOverrun); end
    driveFrame(0, 16'h0266, 10);
    checks++; if (aRxOverrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b want 1", aRxOverrun); end
    checks++; if (aRxData !== 8'h11) begin errors++; $display("[TB] FAIL ovr_head0: got %h want 11", aRxData); end
    aRxReady = 1'b1;
    @(negedge clk);
    aRxReady = 1'b0;
    checks++; if (aRxData !== 8'h22) begin errors++; $display("[TB] FAIL ovr_head1: got %h want 22", aRxData); end
    checks++; if (aRxValid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid1: got %b want 1", aRxValid); end
    aRxReady = 1'b1;
    @(negedge clk);
    aRxReady = 1'b0;
    checks++; if (aRxValid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_drained: got %b want 0", aRxValid); end
    checks++; if (aRxOverrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %b want 1", aRxOverrun); end
    aOvrClr = 1'b1;
    @(negedge clk);
    aOvrClr = 1'b0;
    checks++; if (aRxOverrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b want 0", aRxOverrun); end
  endtask

  // Queue 0x77 in the FIFO, start sending 0xA5, reset at frame bit 4 (low).
  task automatic test_midframe_reset();
    driveFrame(0, 16'h02EE, 10);
    checks++; if (aRxValid !== 1'b1) begin errors++; $display("[TB] FAIL mr_queued: got %b want 1", aRxValid); end
    aTxData = 8'hA5; aTxValid = 1'b1;
    @(negedge clk);
    aTxValid = 1'b0;
    repeat (4 * T + T / 2) @(negedge clk);
    checks++; if ({aTxd, aTxReady} !== 2'b00) begin errors++; $display("[TB] FAIL mr_bit4: got %b want 00", {aTxd, aTxReady}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({aTxd, aTxReady} !== 2'b11) begin errors++; $display("[TB] FAIL mr_tx_reset: got %b want 11", {aTxd, aTxReady}); end
    checks++; if (aRxValid !== 1'b0) begin errors++; $display("[TB] FAIL mr_fifo_empty: got %b want 0", aRxValid); end
    checks++; if (aRxData !== 8'h00) begin errors++; $display("[TB] FAIL mr_rx_data: got %h want 00", aRxData); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    $display("[TB] uart_xcvr directed bench");
    test_reset();
    test_tx_frame();
    test_loopback();
    test_parity_error();
    test_framing();
    test_overrun();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
